wb_stage: RTL and testbench

- Writeback stage of the NaiveMIPS pipeline, directly downstream of the memory stage.
- Captures the retiring instruction from the memory stage into a MEM/WB register.
- For loads, waits for the data bus read response and aligns or merges the returned word (LB/LBU/LH/LHU/LW/LWL/LWR, little-endian).
- Drives the register-file write port and stalls the pipeline while a load response is outstanding.

---
 rtl/wb_stage.sv | 173 +++++++++++++++++
 tb/tb_wb_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// NaiveMIPS writeback stage: MEM/WB capture, load response alignment/merge, register-file write.
// Optional load timeout (bus_err) enabled by defining WB_TIMEOUT_EN.
module wb_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mm_valid,
  input  logic        mm_except,
  input  logic        mm_load,
  input  logic [2:0]  mm_ltype,
  input  logic [1:0]  mm_addr_lo,
  input  logic [4:0]  mm_dest,
  input  logic [31:0] mm_result,
  input  logic [31:0] mm_rt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_r;
  logic [2:0]  ltype_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  dest_r;
  logic [31:0] result_r;
  logic [31:0] rt_r;
  logic        pend_r;
  logic        cap_s;

  if (TIMEOUT >= (1 << CNT_W)) begin : g_cnt_w_too_small
  end

  function automatic logic [31:0] align_load(input logic [2:0] lt, input logic [1:0] b,
                                             input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (b)
      2'd0:    byte_v = rd[7:0];
      2'd1:    byte_v = rd[15:8];
      2'd2:    byte_v = rd[23:16];
      default: byte_v = rd[31:24];
    endcase
    half_v = b[1] ? rd[31:16] : rd[15:0];
    case (lt)
      3'd0: res = {{24{byte_v[7]}}, byte_v};
      3'd1: res = {24'd0, byte_v};
      3'd2: res = {{16{half_v[15]}}, half_v};
      3'd3: res = {16'd0, half_v};
      3'd5: begin
        case (b)
          2'd0:    res = {rd[7:0], rt[23:0]};
          2'd1:    res = {rd[15:0], rt[15:0]};
          2'd2:    res = {rd[23:0], rt[7:0]};
          default: res = rd;
        endcase
      end
      3'd6: begin
        case (b)
          2'd0:    res = rd;
          2'd1:    res = {rt[31:24], rd[31:8]};
          2'd2:    res = {rt[31:16], rd[31:16]};
          default: res = {rt[31:8], rd[31:24]};
        endcase
      end
      default: res = rd;
    endcase
    return res;
  endfunction

  assign wb_stall = (state_r == WAIT) & ~dbus_rvalid;
  assign cap_s    = mm_valid & ~mm_except & ~flush & ~wb_stall;

`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;
`else
  assign bus_err = 1'b0;
`endif

  // State machine, MEM/WB register and registered write port.
  // A non-load captured on the edge that completes a load is parked (pend_r) and
  // written one cycle later, keeping writes in program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ltype_r   <= 3'd0;
      addr_lo_r <= 2'd0;
      dest_r    <= 5'd0;
      result_r  <= 32'd0;
      rt_r      <= 32'd0;
      pend_r    <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
`ifdef WB_TIMEOUT_EN
      cnt_r     <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
`ifdef WB_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      if (cap_s) begin
        ltype_r   <= mm_ltype;
        addr_lo_r <= mm_addr_lo;
        dest_r    <= mm_dest;
        result_r  <= mm_result;
        rt_r      <= mm_rt;
      end
      case (state_r)
        IDLE: begin
          if (pend_r) begin
            rf_we    <= (dest_r != 5'd0);
            rf_waddr <= dest_r;
            rf_wdata <= result_r;
            pend_r   <= 1'b0;
          end
          if (cap_s) begin
            if (mm_load) begin
              state_r <= WAIT;
`ifdef WB_TIMEOUT_EN
              cnt_r   <= '0;
`endif
            end else if (pend_r) begin
              pend_r <= 1'b1;
            end else begin
              rf_we    <= (mm_dest != 5'd0);
              rf_waddr <= mm_dest;
              rf_wdata <= mm_result;
            end
          end
        end
        WAIT: begin
          if (dbus_rvalid) begin
            rf_we    <= (dest_r != 5'd0);
            rf_waddr <= dest_r;
            rf_wdata <= align_load(ltype_r, addr_lo_r, dbus_rdata, rt_r);
            state_r  <= IDLE;
            if (cap_s) begin
              if (mm_load) begin
                state_r <= WAIT;
`ifdef WB_TIMEOUT_EN
                cnt_r   <= '0;
`endif
              end else begin
                pend_r <= 1'b1;
              end
            end
          end else begin
`ifdef WB_TIMEOUT_EN
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
              bus_err <= 1'b1;
              state_r <= IDLE;
            end
`endif
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed steps, then randomized traffic against a reference model.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, mm_valid, mm_except, mm_load, dbus_rvalid;
  logic [2:0]  mm_ltype;
  logic [1:0]  mm_addr_lo;
  logic [4:0]  mm_dest;
  logic [31:0] mm_result, mm_rt, dbus_rdata;
  logic        wb_stall, rf_we, bus_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic st;

  wb_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mm_valid(mm_valid), .mm_except(mm_except),
    .mm_load(mm_load), .mm_ltype(mm_ltype), .mm_addr_lo(mm_addr_lo), .mm_dest(mm_dest),
    .mm_result(mm_result), .mm_rt(mm_rt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample the combinational stall just before the edge, then advance one cycle.
  task automatic tick(output logic stall_pre);
    #1 stall_pre = wb_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mm_valid = 1'b0; mm_except = 1'b0; flush = 1'b0; mm_load = 1'b0;
    dbus_rvalid = 1'b0;
  endtask

  task automatic put(input logic ld, input logic [2:0] lt, input logic [1:0] b,
                     input logic [4:0] d, input logic [31:0] res, input logic [31:0] rt);
    mm_valid = 1'b1; mm_load = ld; mm_ltype = lt; mm_addr_lo = b;
    mm_dest = d; mm_result = res; mm_rt = rt;
  endtask

  task automatic run_load(input string tag, input logic [2:0] lt, input logic [1:0] b,
                          input logic [4:0] d, input logic [31:0] rt, input logic [31:0] rd,
                          input int waits, input logic [31:0] exp);
    put(1'b1, lt, b, d, $urandom, rt);
    tick(st);
    chk({tag, "_cap_stall"}, st, 1'b0);
    chk({tag, "_cap_we"}, rf_we, 1'b0);
    idle_in();
    for (int i = 0; i < waits; i++) begin
      tick(st);
      chk({tag, "_wait_stall"}, st, 1'b1);
      chk({tag, "_wait_we"}, rf_we, 1'b0);
    end
    dbus_rvalid = 1'b1; dbus_rdata = rd;
    tick(st);
    chk({tag, "_rv_stall"}, st, 1'b0);
    chk({tag, "_we"}, rf_we, (d != 5'd0));
    chk({tag, "_waddr"}, rf_waddr, d);
    chk({tag, "_wdata"}, rf_wdata, exp);
    dbus_rvalid = 1'b0;
  endtask

  // Load result computed from the byte-lane rules with shifts and masks.
  function automatic logic [31:0] ref_align(input int lt, input int b,
                                            input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] sh, hw, ones;
    ones = 32'hFFFF_FFFF;
    sh = rd >> (8 * b);
    hw = rd >> (16 * (b / 2));
    case (lt)
      0: return {{24{sh[7]}}, sh[7:0]};
      1: return sh & 32'h0000_00FF;
      2: return {{16{hw[15]}}, hw[15:0]};
      3: return hw & 32'h0000_FFFF;
      5: return (rd << (8 * (3 - b))) | (rt & (ones >> (8 * (b + 1))));
      6: return (rd >> (8 * b)) | (rt & ~(ones >> (8 * b)));
      default: return rd;
    endcase
  endfunction

  logic [36:0] expq[$];
  logic        m_wait;
  int          m_waited, m_lt, m_b;
  logic [4:0]  m_dest;
  logic [31:0] m_rt;
  logic [36:0] head;
  logic        exp_stall;

  initial begin
    idle_in();
    rst_n = 1'b0; mm_ltype = 3'd0; mm_addr_lo = 2'd0; mm_dest = 5'd0;
    mm_result = 32'd0; mm_rt = 32'd0; dbus_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_buserr", bus_err, 1'b0);
    chk("rst_stall", wb_stall, 1'b0);
    rst_n = 1'b1;

    // Non-load with real and zero destination.
    put(1'b0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'd0);
    tick(st);
    chk("alu_we", rf_we, 1'b1);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    idle_in();
    tick(st);
    chk("alu_we_drop", rf_we, 1'b0);
    put(1'b0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'd0);
    tick(st);
    chk("alu_r0_we", rf_we, 1'b0);
    idle_in();

    run_load("lb",  3'd0, 2'd2, 5'd3, 32'd0, 32'h0080_0000, 3, 32'hFFFF_FF80);
    run_load("lbu", 3'd1, 2'd2, 5'd3, 32'd0, 32'h0080_0000, 3, 32'h0000_0080);
    run_load("lwl", 3'd5, 2'd1, 5'd9, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'h3344_CCDD);
    run_load("lwr", 3'd6, 2'd1, 5'd9, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAA11_2233);
    run_load("lh_hi", 3'd2, 2'd3, 5'd4, 32'd0, 32'h8001_7FFF, 2, 32'hFFFF_8001);
    run_load("lw_r0", 3'd4, 2'd0, 5'd0, 32'd0, 32'h5555_AAAA, 1, 32'h5555_AAAA);

    // Back-to-back LW, LW, ADD with single-cycle responses.
    put(1'b1, 3'd4, 2'd0, 5'd10, 32'd0, 32'd0);
    tick(st); chk("b2b_stall0", st, 1'b0);
    put(1'b1, 3'd4, 2'd0, 5'd11, 32'd0, 32'd0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'hA0A0_0001;
    tick(st); chk("b2b_stall1", st, 1'b0);
    chk("b2b_we1", rf_we, 1'b1); chk("b2b_a1", rf_waddr, 5'd10); chk("b2b_d1", rf_wdata, 32'hA0A0_0001);
    put(1'b0, 3'd0, 2'd0, 5'd12, 32'hC0DE_0003, 32'd0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'hA0A0_0002;
    tick(st); chk("b2b_stall2", st, 1'b0);
    chk("b2b_we2", rf_we, 1'b1); chk("b2b_a2", rf_waddr, 5'd11); chk("b2b_d2", rf_wdata, 32'hA0A0_0002);
    idle_in();
    tick(st); chk("b2b_stall3", st, 1'b0);
    chk("b2b_we3", rf_we, 1'b1); chk("b2b_a3", rf_waddr, 5'd12); chk("b2b_d3", rf_wdata, 32'hC0DE_0003);
    tick(st); chk("b2b_we_end", rf_we, 1'b0);

    // Flush during WAIT must not cancel the older pending load.
    put(1'b1, 3'd4, 2'd0, 5'd20, 32'd0, 32'd0);
    tick(st);
    put(1'b0, 3'd0, 2'd0, 5'd21, 32'h0BAD_0BAD, 32'd0);
    flush = 1'b1;
    tick(st); chk("fl_stall", st, 1'b1); chk("fl_we0", rf_we, 1'b0);
    idle_in();
    dbus_rvalid = 1'b1; dbus_rdata = 32'h7777_1234;
    tick(st);
    chk("fl_we", rf_we, 1'b1); chk("fl_waddr", rf_waddr, 5'd20); chk("fl_wdata", rf_wdata, 32'h7777_1234);
    idle_in();
    tick(st); chk("fl_no_extra", rf_we, 1'b0);

    // Flush / exception in IDLE, and stray rvalid in IDLE.
    put(1'b0, 3'd0, 2'd0, 5'd22, 32'h1, 32'd0); flush = 1'b1;
    tick(st); chk("flush_idle_we", rf_we, 1'b0);
    flush = 1'b0; mm_except = 1'b1;
    tick(st); chk("except_we", rf_we, 1'b0);
    idle_in();
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    tick(st); chk("rv_idle_we", rf_we, 1'b0); chk("rv_idle_stall", st, 1'b0);
    dbus_rvalid = 1'b0;
    tick(st); chk("rv_idle_stall2", st, 1'b0);

    // Reset while waiting, then a late response.
    put(1'b1, 3'd4, 2'd0, 5'd6, 32'd0, 32'd0);
    tick(st);
    idle_in();
    tick(st); chk("rw_stall", st, 1'b1);
    rst_n = 1'b0; #1;
    chk("rw_we", rf_we, 1'b0); chk("rw_waddr", rf_waddr, 5'd0); chk("rw_wdata", rf_wdata, 32'd0);
    chk("rw_stall_rst", wb_stall, 1'b0); chk("rw_buserr", bus_err, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1357_9BDF;
    tick(st); chk("late_rv_stall", st, 1'b0); chk("late_rv_we", rf_we, 1'b0);
    dbus_rvalid = 1'b0;

`ifdef WB_TIMEOUT_EN
    // LH that never gets a response: abandoned after 4 stalled cycles.
    put(1'b1, 3'd2, 2'd0, 5'd7, 32'd0, 32'd0);
    tick(st);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      tick(st); chk("to_stall", st, 1'b1);
      chk("to_we", rf_we, 1'b0);
    end
    chk("to_buserr", bus_err, 1'b1);
    chk("to_stall_after", wb_stall, 1'b0);
    tick(st); chk("to_buserr_drop", bus_err, 1'b0); chk("to_we_after", rf_we, 1'b0);
`endif

    // Randomized traffic against the reference model.
    m_wait = 1'b0; m_waited = 0; m_lt = 0; m_b = 0; m_dest = 5'd0; m_rt = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      mm_valid   = ($urandom_range(0, 3) != 0);
      mm_except  = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      mm_load    = $urandom_range(0, 1);
      mm_ltype   = 3'($urandom_range(0, 7));
      mm_addr_lo = 2'($urandom_range(0, 3));
      mm_dest    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mm_result  = $urandom;
      mm_rt      = $urandom;
      dbus_rdata = $urandom;
      if (m_wait) dbus_rvalid = (m_waited >= 3) ? 1'b1 : ($urandom_range(0, 2) == 0);
      else        dbus_rvalid = ($urandom_range(0, 7) == 0);

      exp_stall = m_wait && !dbus_rvalid;
      if (m_wait && dbus_rvalid) begin
        if (m_dest != 5'd0) expq.push_back({m_dest, ref_align(m_lt, m_b, dbus_rdata, m_rt)});
        m_wait = 1'b0;
      end else if (m_wait) begin
        m_waited++;
      end
      if (mm_valid && !mm_except && !flush && !exp_stall) begin
        if (mm_load) begin
          m_wait = 1'b1; m_waited = 0;
          m_lt = int'(mm_ltype); m_b = int'(mm_addr_lo); m_dest = mm_dest; m_rt = mm_rt;
        end else if (mm_dest != 5'd0) begin
          expq.push_back({mm_dest, mm_result});
        end
      end

      tick(st);
      chk("rnd_stall", st, exp_stall);
      chk("rnd_buserr", bus_err, 1'b0);
      if (rf_we) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious_we", rf_we, 1'b0);
        end else begin
          head = expq.pop_front();
          chk("rnd_waddr", rf_waddr, head[36:32]);
          chk("rnd_wdata", rf_wdata, head[31:0]);
        end
      end
      chk("rnd_backlog", (expq.size() <= 1), 1'b1);
    end

    // Drain: finish any outstanding load and deferred write.
    idle_in();
    dbus_rvalid = m_wait; dbus_rdata = 32'h0F0F_F0F0;
    if (m_wait && m_dest != 5'd0) expq.push_back({m_dest, ref_align(m_lt, m_b, 32'h0F0F_F0F0, m_rt)});
    m_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(st);
      dbus_rvalid = 1'b0;
      if (rf_we) begin
        if (expq.size() == 0) begin
          chk("drain_spurious_we", rf_we, 1'b0);
        end else begin
          head = expq.pop_front();
          chk("drain_waddr", rf_waddr, head[36:32]);
          chk("drain_wdata", rf_wdata, head[31:0]);
        end
      end
    end
    chk("drain_empty", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
